// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Wishbone B3 registered-feedback burst constants and the
//               shared burst address stepping function. The responder-side
//               incrementer uses the same function so both ends of a burst
//               always agree on the address sequence.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Burst type extensions
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Widest address the stepping function handles; callers zero-extend
   // into this width and keep only their own low bits of the result.
   localparam int WB_ADR_MAX = 64;

   // Next word address of a burst. Linear steps the whole word and rolls
   // over at the caller's width once truncated; wrap modes step only the
   // low 2/3/4 bits and leave the upper bits untouched.
   function automatic logic [WB_ADR_MAX-1:0] wb_next_adr(
      input logic [WB_ADR_MAX-1:0] adr,
      input logic [1:0]            bte
   );
      logic [WB_ADR_MAX-1:0] nxt;
      nxt = adr;
      case (bte)
         BTE_LINEAR: nxt = adr + 64'd1;
         BTE_WRAP4:  nxt[1:0] = adr[1:0] + 2'd1;
         BTE_WRAP8:  nxt[2:0] = adr[2:0] + 3'd1;
         BTE_WRAP16: nxt[3:0] = adr[3:0] + 4'd1;
         default:    nxt = adr + 64'd1;
      endcase
      return nxt;
   endfunction

   // Number of beats in a burst: len+1 for linear, fixed for wrap modes.
   function automatic logic [4:0] wb_burst_beats(
      input logic [1:0] bte,
      input logic [3:0] len
   );
      logic [4:0] beats;
      case (bte)
         BTE_LINEAR: beats = {1'b0, len} + 5'd1;
         BTE_WRAP4:  beats = 5'd4;
         BTE_WRAP8:  beats = 5'd8;
         BTE_WRAP16: beats = 5'd16;
         default:    beats = 5'd1;
      endcase
      return beats;
   endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_burst_rd.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_rd
// Description : Wishbone B3 registered-feedback burst read initiator. Takes a
//               single-cycle burst request, runs the burst on the bus with
//               linear/wrap4/wrap8/wrap16 address stepping, and forwards each
//               acknowledged word to a local consumer that always accepts.
//               An error response terminates the burst immediately.
//               ADR_W must lie in 4..63.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_rd
   import wb_pkg::*;
#(
   parameter int ADR_W = 30,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,

   // Request side
   input  logic             req_i,
   input  logic [ADR_W-1:0] req_adr_i,
   input  logic [1:0]       req_bte_i,
   input  logic [3:0]       req_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,

   // Consumer side
   output logic [DW-1:0]    rd_dat_o,
   output logic             rd_vld_o,

   // Wishbone initiator port
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [2:0]       wbm_cti_o,
   output logic [1:0]       wbm_bte_o,
   input  logic [DW-1:0]    wbm_dat_i,
   input  logic             wbm_ack_i,
   input  logic             wbm_err_i
);

   localparam logic [0:0] c_ST_IDLE   = 1'b0;
   localparam logic [0:0] c_ST_ACTIVE = 1'b1;

   logic [0:0]            r_state;
   logic                  r_cyc;
   logic                  r_stb;
   logic [ADR_W-1:0]      r_adr;
   logic [2:0]            r_cti;
   logic [1:0]            r_bte;
   logic [4:0]            r_remain;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic [DW-1:0]         r_rd_dat;
   logic                  r_rd_vld;

   logic                  w_start;
   logic                  w_err_beat;
   logic                  w_ack_beat;
   logic                  w_last_beat;
   logic [4:0]            w_req_beats;
   logic [WB_ADR_MAX-1:0] w_adr_next_full;
   logic [ADR_W-1:0]      w_adr_next;
   logic                  w_unused_adr_hi;

   // Request is only honoured while idle; bus responses only while strobing.
   // An error wins over an acknowledge presented in the same cycle.
   assign w_start     = (r_state == c_ST_IDLE) && req_i;
   assign w_err_beat  = (r_state == c_ST_ACTIVE) && r_stb && wbm_err_i;
   assign w_ack_beat  = (r_state == c_ST_ACTIVE) && r_stb && wbm_ack_i && !wbm_err_i;
   assign w_last_beat = w_ack_beat && (r_remain == 5'd1);
   assign w_req_beats = wb_burst_beats(req_bte_i, req_len_i);

   assign w_adr_next_full = wb_next_adr({{(WB_ADR_MAX-ADR_W){1'b0}}, r_adr}, r_bte);
   assign w_adr_next      = w_adr_next_full[ADR_W-1:0];
   // Upper bits only carry the linear rollover, which truncation discards.
   assign w_unused_adr_hi = ^w_adr_next_full[WB_ADR_MAX-1:ADR_W];

   // Burst FSM and bus signalling: start on request, step on ack, stop on
   // last ack or on error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_adr   <= '0;
         r_cti   <= CTI_CLASSIC;
         r_bte   <= BTE_LINEAR;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_start) begin
                  r_state <= c_ST_ACTIVE;
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_adr   <= req_adr_i;
                  r_bte   <= req_bte_i;
                  r_cti   <= (w_req_beats == 5'd1) ? CTI_CLASSIC : CTI_INC;
               end
            end
            c_ST_ACTIVE: begin
               if (w_err_beat || w_last_beat) begin
                  r_state <= c_ST_IDLE;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_cti   <= CTI_CLASSIC;
                  r_bte   <= BTE_LINEAR;
               end else if (w_ack_beat) begin
                  r_adr <= w_adr_next;
                  // Two beats left before this ack means one left after it.
                  if (r_remain == 5'd2) begin
                     r_cti <= CTI_EOB;
                  end
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_busy  <= 1'b0;
               r_cti   <= CTI_CLASSIC;
               r_bte   <= BTE_LINEAR;
            end
         endcase
      end
   end

   // Remaining-beat counter: loaded at burst start, decremented per ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remain <= 5'd0;
      end else if (w_start) begin
         r_remain <= w_req_beats;
      end else if (w_err_beat) begin
         r_remain <= 5'd0;
      end else if (w_ack_beat) begin
         r_remain <= r_remain - 5'd1;
      end
   end

   // Consumer data path and completion pulses; errored beats carry no data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_dat <= '0;
         r_rd_vld <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rd_vld <= w_ack_beat;
         r_done   <= w_last_beat || w_err_beat;
         r_err    <= w_err_beat;
         if (w_ack_beat) begin
            r_rd_dat <= wbm_dat_i;
         end
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign rd_dat_o  = r_rd_dat;
   assign rd_vld_o  = r_rd_vld;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_stb;
   assign wbm_adr_o = r_adr;
   assign wbm_cti_o = r_cti;
   assign wbm_bte_o = r_bte;

endmodule : wb_burst_rd
`default_nettype wire

// File: tb/tb_wb_burst_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_burst_rd
// Description : Self-checking bench for wb_burst_rd. Stimulus pushes the
//               hand-computed address/cti/data/termination expectations into
//               queues; a slave model and monitors pop and compare as the DUT
//               presents beats, read data and completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_burst_rd;
   import wb_pkg::*;

   localparam int ADR_W = 30;
   localparam int DW    = 32;

   logic             clk;
   logic             rst_n;
   logic             req_i;
   logic [ADR_W-1:0] req_adr_i;
   logic [1:0]       req_bte_i;
   logic [3:0]       req_len_i;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [DW-1:0]    rd_dat_o;
   logic             rd_vld_o;
   logic             wbm_cyc_o;
   logic             wbm_stb_o;
   logic [ADR_W-1:0] wbm_adr_o;
   logic [2:0]       wbm_cti_o;
   logic [1:0]       wbm_bte_o;
   logic [DW-1:0]    wbm_dat_i;
   logic             wbm_ack_i;
   logic             wbm_err_i;

   wb_burst_rd #(.ADR_W(ADR_W), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .req_adr_i (req_adr_i),
      .req_bte_i (req_bte_i),
      .req_len_i (req_len_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .rd_dat_o  (rd_dat_o),
      .rd_vld_o  (rd_vld_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_cti_o (wbm_cti_o),
      .wbm_bte_o (wbm_bte_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [29:0] exp_adr_q[$];
   logic [2:0]  exp_cti_q[$];
   logic [31:0] exp_dat_q[$];
   logic        exp_err_q[$];
   logic [29:0] plan[$];

   int slv_waits    = 0;
   int slv_err_beat = 0;
   int slv_beat     = 0;
   int slv_wcnt     = 0;
   int done_seen    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave read data is a fixed scramble of the word address.
   function automatic logic [31:0] dat_of(input logic [29:0] a);
      return {2'b10, a} ^ 32'h0F0F_F0F0;
   endfunction

   // Turn the hand-written address plan into per-beat expectations.
   task automatic expect_plan(input int beats_total, input int data_beats);
      for (int i = 0; i < plan.size(); i++) begin
         exp_adr_q.push_back(plan[i]);
         if (beats_total == 1)            exp_cti_q.push_back(CTI_CLASSIC);
         else if (i == beats_total - 1)   exp_cti_q.push_back(CTI_EOB);
         else                             exp_cti_q.push_back(CTI_INC);
         if (i < data_beats) exp_dat_q.push_back(dat_of(plan[i]));
      end
   endtask

   // Called at a negedge; raises req for one edge and checks the entry state.
   task automatic issue(input logic [29:0] adr, input logic [1:0] bte,
                        input logic [3:0] len, input logic exp_err);
      exp_err_q.push_back(exp_err);
      slv_beat  = 0;
      req_i     = 1'b1;
      req_adr_i = adr;
      req_bte_i = bte;
      req_len_i = len;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      chk("start_busy", 64'(busy_o), 64'd1);
      chk("start_cyc_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'd3);
      chk("start_adr", 64'(wbm_adr_o), 64'(adr));
      chk("start_bte", 64'(wbm_bte_o), 64'(bte));
      if (exp_cti_q.size() > 0) chk("start_cti", 64'(wbm_cti_o), 64'(exp_cti_q[0]));
   endtask

   // Waits for the done pulse; returns the number of cycles before it.
   task automatic wait_done(input int budget, output int ncyc);
      int start;
      start = done_seen;
      ncyc  = 0;
      while (ncyc < budget) begin
         @(negedge clk);
         #1;
         if (done_seen != start) break;
         ncyc++;
      end
      chk("done_within_budget", 64'(done_seen != start), 64'd1);
      chk("adr_q_drained", 64'(exp_adr_q.size()), 64'd0);
      chk("dat_q_drained", 64'(exp_dat_q.size()), 64'd0);
      chk("err_q_drained", 64'(exp_err_q.size()), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cyc"},    64'(wbm_cyc_o), 64'd0);
      chk({tag, "_stb"},    64'(wbm_stb_o), 64'd0);
      chk({tag, "_adr"},    64'(wbm_adr_o), 64'd0);
      chk({tag, "_cti"},    64'(wbm_cti_o), 64'd0);
      chk({tag, "_bte"},    64'(wbm_bte_o), 64'd0);
      chk({tag, "_busy"},   64'(busy_o),    64'd0);
      chk({tag, "_done"},   64'(done_o),    64'd0);
      chk({tag, "_err"},    64'(err_o),     64'd0);
      chk({tag, "_rd_vld"}, 64'(rd_vld_o),  64'd0);
      chk({tag, "_rd_dat"}, 64'(rd_dat_o),  64'd0);
   endtask

   // Slave model: inserts wait states, checks each accepted beat and that the
   // bus holds still during waits, and optionally errors a chosen beat.
   always @(negedge clk) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = 32'hDEAD_BEEF;
      if (rst_n && wbm_cyc_o && wbm_stb_o) begin
         if (slv_wcnt < slv_waits) begin
            slv_wcnt++;
            if (exp_adr_q.size() > 0) begin
               chk("wait_hold_adr", 64'(wbm_adr_o), 64'(exp_adr_q[0]));
               chk("wait_hold_cti", 64'(wbm_cti_o), 64'(exp_cti_q[0]));
            end
         end else begin
            slv_wcnt = 0;
            slv_beat++;
            if (exp_adr_q.size() == 0) begin
               chk("beat_unexpected", 64'(wbm_adr_o), 64'h1_0000_0000);
            end else begin
               chk("beat_adr", 64'(wbm_adr_o), 64'(exp_adr_q.pop_front()));
               chk("beat_cti", 64'(wbm_cti_o), 64'(exp_cti_q.pop_front()));
            end
            if (slv_beat == slv_err_beat) begin
               wbm_err_i = 1'b1;
            end else begin
               wbm_ack_i = 1'b1;
               wbm_dat_i = dat_of(wbm_adr_o);
            end
         end
      end else begin
         slv_wcnt = 0;
      end
   end

   // Consumer monitor: every rd_vld pulse must match the next expected word.
   always @(negedge clk) begin
      if (rst_n && rd_vld_o) begin
         if (exp_dat_q.size() == 0) chk("rd_vld_unexpected", 64'd1, 64'd0);
         else                       chk("rd_dat", 64'(rd_dat_o), 64'(exp_dat_q.pop_front()));
      end
   end

   // Completion monitor: done pulse, error flag and the idle bus around it.
   always @(negedge clk) begin
      if (rst_n && err_o && !done_o) chk("err_without_done", 64'd1, 64'd0);
      if (rst_n && done_o) begin
         done_seen++;
         if (exp_err_q.size() == 0) begin
            chk("done_unexpected", 64'd1, 64'd0);
         end else begin
            logic e;
            e = exp_err_q.pop_front();
            chk("done_err", 64'(err_o), 64'(e));
            chk("done_rd_vld", 64'(rd_vld_o), 64'(!e));
         end
         chk("done_cyc_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
         chk("done_busy", 64'(busy_o), 64'd0);
         chk("done_cti_bte", 64'({wbm_cti_o, wbm_bte_o}), 64'd0);
      end
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      req_i     = 1'b0;
      req_adr_i = '0;
      req_bte_i = 2'b00;
      req_len_i = 4'd0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Classic single beat
      plan = '{30'h10};
      expect_plan(1, 1);
      issue(30'h10, BTE_LINEAR, 4'd0, 1'b0);
      wait_done(50, n);
      chk("classic_cycles", 64'(n), 64'd1);

      // Wrap4 from 0x0E, no waits
      plan = '{30'h0E, 30'h0F, 30'h0C, 30'h0D};
      expect_plan(4, 4);
      issue(30'h0E, BTE_WRAP4, 4'd9, 1'b0);
      wait_done(50, n);
      chk("wrap4_cycles", 64'(n), 64'd4);

      // Wrap16 from 0x23
      plan = '{30'h23, 30'h24, 30'h25, 30'h26, 30'h27, 30'h28, 30'h29, 30'h2A,
               30'h2B, 30'h2C, 30'h2D, 30'h2E, 30'h2F, 30'h20, 30'h21, 30'h22};
      expect_plan(16, 16);
      issue(30'h23, BTE_WRAP16, 4'd0, 1'b0);
      wait_done(80, n);
      chk("wrap16_cycles", 64'(n), 64'd16);

      // Linear rollover, issued back-to-back in the done cycle
      plan = '{30'h3FFF_FFFE, 30'h3FFF_FFFF, 30'h0, 30'h1};
      expect_plan(4, 4);
      issue(30'h3FFF_FFFE, BTE_LINEAR, 4'd3, 1'b0);
      wait_done(50, n);
      chk("linear_roll_cycles", 64'(n), 64'd4);

      // Wrap8 from 0x05 with two wait states before every beat
      slv_waits = 2;
      plan = '{30'h05, 30'h06, 30'h07, 30'h00, 30'h01, 30'h02, 30'h03, 30'h04};
      expect_plan(8, 8);
      issue(30'h05, BTE_WRAP8, 4'd0, 1'b0);
      wait_done(100, n);
      chk("wrap8_wait_cycles", 64'(n), 64'd24);

      // Error on beat 2 of a linear 8-beat burst, with a stray mid-burst req
      slv_waits    = 1;
      slv_err_beat = 2;
      plan = '{30'h200, 30'h201};
      expect_plan(8, 1);
      issue(30'h200, BTE_LINEAR, 4'd7, 1'b1);
      @(negedge clk);
      req_i     = 1'b1;
      req_adr_i = 30'h3AB;
      req_bte_i = BTE_WRAP4;
      @(negedge clk);
      req_i = 1'b0;
      wait_done(50, n);
      @(negedge clk);
      #1;
      chk("after_err_idle", 64'({busy_o, wbm_cyc_o}), 64'd0);
      slv_waits    = 0;
      slv_err_beat = 0;

      // Reset during beat 3 of a linear burst
      plan = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h104, 30'h105, 30'h106, 30'h107};
      expect_plan(8, 8);
      issue(30'h100, BTE_LINEAR, 4'd7, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("pre_reset_adr", 64'(wbm_adr_o), 64'h102);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      exp_adr_q.delete();
      exp_cti_q.delete();
      exp_dat_q.delete();
      exp_err_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Clean restart: wrap8 from 0x2D
      plan = '{30'h2D, 30'h2E, 30'h2F, 30'h28, 30'h29, 30'h2A, 30'h2B, 30'h2C};
      expect_plan(8, 8);
      issue(30'h2D, BTE_WRAP8, 4'd0, 1'b0);
      wait_done(50, n);
      chk("restart_cycles", 64'(n), 64'd8);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_wb_burst_rd
`default_nettype wire
